// File: rtl/axis_deser_pkg.sv
// Shared definitions for the AXI4-Stream byte deserializer: width helpers,
// default geometry and the idle-counter width used by the optional timeout.
package axis_deser_pkg;

  // Default geometry; the top module recomputes these from its own parameters.
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_WORD_W     = DEF_DATA_WIDTH * DEF_WORD_BYTES;

  // Width of the inter-byte idle counter.
  localparam int IDLE_CNT_W = 16;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Byte-count width: enough for 0..WORD_BYTES-1, never narrower than 1 bit.
  function automatic int cnt_width(input int word_bytes);
    int w;
    w = clog2(word_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_word_reg.sv
// Single-entry AXI4-Stream output holding register. A word is loaded with
// load_i and held stable until the downstream handshake; a load in the same
// cycle as a handshake replaces the word with no bubble.
module axis_word_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             m_tvalid_o,
  output logic [WIDTH-1:0] m_tdata_o,
  input  logic             m_tready_i
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // The register can take a new word when empty or when its word leaves now.
  assign ready_o    = !valid_q || m_tready_i;
  assign m_tvalid_o = valid_q;
  assign m_tdata_o  = data_q;

  // Next-state: load wins over drain so back-to-back words keep tvalid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (m_tready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/axis_byte_deser.sv
// Packs WORD_BYTES consecutive AXI4-Stream bytes into one wide word.
// Optional feature macro: AXIS_DESER_TIMEOUT_EN enables the inter-byte idle
// timeout that discards a stale partial word.
module axis_byte_deser
  import axis_deser_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int WORD_BYTES     = 4,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clk,
  input  logic                             arstn,
  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  input  logic                             clr,
  output logic                             busy,
  output logic [cnt_width(WORD_BYTES)-1:0] byte_cnt,
  output logic                             timeout_error
);

  localparam int WORD_W = DATA_WIDTH * WORD_BYTES;
  localparam int CNT_W  = cnt_width(WORD_BYTES);

  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              lastByte;
  logic              accept;
  logic              wordReady;
  logic              loadWord;
  logic              timeoutFire;

  assign lastByte      = (cnt_q == CNT_W'(WORD_BYTES - 1));
  // Only the completing byte waits for room in the output register.
  assign s_axis_tready = !lastByte || wordReady;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign loadWord      = accept && lastByte && !clr;
  assign byte_cnt      = cnt_q;
  assign busy          = (cnt_q != '0);

  // Accumulator with the incoming byte shifted in on the configured side.
  generate
    if (WORD_BYTES == 1) begin : g_single
      assign shifted = s_axis_tdata;
    end else if (MSB_FIRST != 0) begin : g_msb
      assign shifted = {acc_q[WORD_W-DATA_WIDTH-1:0], s_axis_tdata};
    end else begin : g_lsb
      assign shifted = {s_axis_tdata, acc_q[WORD_W-1:DATA_WIDTH]};
    end
  endgenerate

  // Next-state for the byte counter and accumulator; clr discards everything.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = shifted;
      cnt_d = lastByte ? '0 : cnt_q + CNT_W'(1);
    end else if (timeoutFire) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // Partial-word state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef AXIS_DESER_TIMEOUT_EN
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic                  timeoutErr_q;

  // An accepted byte or clr in the expiry cycle pre-empts the timeout.
  assign timeoutFire   = busy && !accept && !clr &&
                         (idle_q == IDLE_CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_error = timeoutErr_q;

  // Idle counter runs only while a partial word waits for its next byte.
  always_comb begin
    idle_d = idle_q + IDLE_CNT_W'(1);
    if (accept || clr || !busy || timeoutFire) begin
      idle_d = '0;
    end
  end

  // Idle counter and one-cycle timeout pulse registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      idle_q       <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      idle_q       <= idle_d;
      timeoutErr_q <= timeoutFire;
    end
  end
`else
  assign timeoutFire   = 1'b0;
  assign timeout_error = 1'b0;
`endif

  axis_word_reg #(
    .WIDTH(WORD_W)
  ) u_word_reg (
    .clk       (clk),
    .arstn     (arstn),
    .load_i    (loadWord),
    .data_i    (shifted),
    .ready_o   (wordReady),
    .m_tvalid_o(m_axis_tvalid),
    .m_tdata_o (m_axis_tdata),
    .m_tready_i(m_axis_tready)
  );

endmodule

// File: doc/axis_byte_deser.md
Name: axis_byte_deser

Overview:
- Sink-side companion to the UART receiver.
- Consumes the receiver's AXI4-Stream byte output and packs WORD_BYTES consecutive bytes into one wide AXI4-Stream word for the network/host-command logic.
- Owns the far end of the byte handshake: backpressure, partial-word tracking, resynchronisation on clear or inter-byte timeout.

Parameters:
- DATA_WIDTH, 8, width of one input beat (byte).
- WORD_BYTES, 4, bytes per output word; legal range 1..16.
- MSB_FIRST, 1, 1 = first byte received lands in the most significant byte; 0 = first byte lands in the least significant byte.
- TIMEOUT_CYCLES, 65535, idle clk cycles before a partial word is discarded (only with AXIS_DESER_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  input byte
- s_axis_tvalid  in  1  input byte valid
- s_axis_tready  out  1  input byte accepted when high with tvalid
- m_axis_tdata  out  DATA_WIDTH*WORD_BYTES  assembled word
- m_axis_tvalid  out  1  word valid
- m_axis_tready  in  1  downstream ready
- clr  in  1  synchronous discard of the partial word
- busy  out  1  partial word in progress (byte count != 0)
- byte_cnt  out  CNT_W  bytes held in the accumulator; CNT_W = max(1, clog2(WORD_BYTES))
- timeout_error  out  1  one-cycle pulse when a partial word is discarded by timeout

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, accumulator=0, byte_cnt=0, busy=0, timeout_error=0, timeout counter=0.
- Reset mid-word or mid-stall drops everything immediately.
- Accept: byte accepted on a cycle with s_axis_tvalid && s_axis_tready.
- s_axis_tready (combinational): (byte_cnt != WORD_BYTES-1) || !m_axis_tvalid || m_axis_tready.
  - Partial bytes keep accumulating while the output is stalled.
  - Only the completing byte is back-pressured.
- Accumulator shift:
  - MSB_FIRST=1: acc <= {acc[low (WORD_BYTES-1) bytes], byte}.
  - MSB_FIRST=0: acc <= {byte, acc[high (WORD_BYTES-1) bytes]}.
- Completing byte (byte_cnt == WORD_BYTES-1):
  - Output register loads the shifted value; m_axis_tvalid=1 on the next edge.
  - byte_cnt returns to 0.
  - Latency: completing byte accepted at edge N, word visible after edge N (one register).
- Output hold: m_axis_tdata/tvalid are stable while tvalid && !tready. tvalid clears after a tready handshake unless a new word loads in the same cycle; in that case tvalid stays 1 with the new data (back-to-back, no bubble).
- byte_cnt increments on each non-completing accept and wraps to 0 on completion. WORD_BYTES=1: every accepted byte completes a word (plain register slice).
- clr:
  - byte_cnt<=0 and accumulator<=0.
  - A held output word is unaffected.
  - A byte accepted in the same cycle is consumed and discarded; clr wins.
  - A completing byte in the same cycle is also discarded; no word is emitted.
- busy = (byte_cnt != 0), registered-equivalent (derived from byte_cnt).
- No protocol errors are possible on the input; all bytes are accepted or back-pressured, none dropped, except by clr or timeout.

Optional Feature:
- AXIS_DESER_TIMEOUT_EN defined:
  - 16-bit idle counter, cleared on every accepted byte, on clr, and whenever byte_cnt==0.
  - Increments each cycle while byte_cnt != 0 and no byte is accepted.
  - On reaching TIMEOUT_CYCLES: byte_cnt<=0, accumulator<=0, counter<=0, timeout_error pulses for exactly 1 cycle.
  - A byte accepted in the expiry cycle wins; no timeout fires.
  - A held output word is never affected.
- Not defined: no counter logic; timeout_error tied 0; partial words persist indefinitely.

Decomposition:
- Package axis_deser_pkg:
  - clog2 helper function and CNT_W derivation.
  - Localparam WORD_W = DATA_WIDTH*WORD_BYTES.
  - Idle-counter width constant (16).
- One natural sub-module: axis_word_reg, a single-entry output holding register with load/tvalid/tready logic. It is reusable by a future word-to-byte serializer on the transmit side.

Test Plan:
- Defaults, MSB_FIRST=1, bytes 0x12,0x34,0x56,0x78 with m_axis_tready=1 -> one word 0x12345678, tvalid for 1 cycle, byte_cnt sequence 1,2,3,0.
- MSB_FIRST=0, same bytes -> word 0x78563412.
- m_axis_tready=0, eight bytes 0x01..0x08 offered continuously:
  - First word 0x01020304 held.
  - Bytes 0x05..0x07 accepted; s_axis_tready=0 on 0x08.
  - Raising tready -> 0x05060708 on the following cycle, no bubble, no byte lost.
- Bytes 0xAA,0xBB, then clr asserted together with valid byte 0xCC, then 0x01,0x02,0x03,0x04 -> only word 0x01020304 emitted; busy=0 after clr.
- AXIS_DESER_TIMEOUT_EN, TIMEOUT_CYCLES=10:
  - Byte 0xAA then idle 10 cycles -> timeout_error single pulse, byte_cnt=0.
  - Then 4 bytes 0x11..0x14 -> word 0x11121314.
  - Idle of 9 cycles between bytes -> no timeout.
- arstn low while tvalid held and byte_cnt=2 -> all outputs return to reset values asynchronously; next 4 bytes form a clean word.
